ram_share_arbiter: RTL and testbench

- Owns the 16x8 program/data RAM port and shares it between the CPU datapath and an external program loader.
- The CPU uses the MAR/RAM strobes issued by the control unit.
- The loader requests the RAM; the arbiter waits for an instruction boundary (or CPU halt), freezes the CPU via its halt input, grants the port, then hands it back.
- Holds the MAR register internally. Timeout guarantees forward progress.

---
 rtl/ram_share_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_share_arbiter.sv
// Arbiter for the shared program/data RAM port: the CPU datapath owns it by default,
// and an external loader can take it over at an instruction boundary or after a timeout.
module ram_share_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_mar_in,
  input  logic              cpu_ram_in,
  input  logic              cpu_ram_out,
  input  logic [DATA_W-1:0] cpu_bus,
  input  logic              cpu_step0,
  input  logic              cpu_halted,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  output logic              ld_grant,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W:0]   ld_count,
  output logic              forced,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [ADDR_W:0]  COUNT_MAX = (ADDR_W + 1)'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    WAIT_BND = 2'd1,
    LOAD_OWN = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   mar;
  logic [CNT_W-1:0]    wait_cnt;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                grant_q;
  logic                hold_q;

  logic cpu_owns;
  logic boundary;
  logic timeout;
  logic ld_accept;
  logic ld_read;

  // Loader handshake: there is no ready. While ld_grant is high and ld_req is still
  // asserted, every cycle with ld_valid=1 is one accepted transfer; a read returns
  // its data with ld_rvalid exactly one cycle later.
  assign cpu_owns  = (state == CPU_OWN) || (state == WAIT_BND);
  assign boundary  = cpu_step0 || cpu_halted;
  assign timeout   = (wait_cnt == WAIT_LAST);
  assign ld_accept = (state == LOAD_OWN) && ld_req && ld_valid;
  assign ld_read   = ld_accept && !ld_we;

  always_comb begin
    next_state = state;
    case (state)
      CPU_OWN:  if (ld_req) next_state = WAIT_BND;
      WAIT_BND: begin
        if (!ld_req)                   next_state = CPU_OWN;
        else if (boundary || timeout)  next_state = LOAD_OWN;
      end
      LOAD_OWN: if (!ld_req) next_state = RELEASE;
      RELEASE:  next_state = CPU_OWN;
      default:  next_state = CPU_OWN;
    endcase
  end

  always_comb begin
    ram_addr  = mar;
    ram_wdata = cpu_bus;
    ram_we    = 1'b0;
    if (cpu_owns) begin
      ram_we = cpu_ram_in;
    end else if (state == LOAD_OWN) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = ld_accept && ld_we;
    end
  end

  // Outside CPU ownership the CPU sees the last word it read, not the loader's traffic.
  assign cpu_rdata = cpu_owns ? ram_rdata : cpu_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CPU_OWN;
      mar         <= '0;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      grant_q     <= 1'b0;
      hold_q      <= 1'b0;
      forced      <= 1'b0;
      ld_count    <= '0;
      ld_rvalid   <= 1'b0;
      ld_rdata    <= '0;
    end else begin
      state   <= next_state;
      grant_q <= (next_state == LOAD_OWN);
      hold_q  <= (next_state == LOAD_OWN);

      if (cpu_owns && cpu_mar_in)  mar         <= cpu_bus[ADDR_W-1:0];
      if (cpu_owns && cpu_ram_out) cpu_rdata_q <= ram_rdata;

      if ((state == WAIT_BND) && (next_state == WAIT_BND)) wait_cnt <= wait_cnt + 1'b1;
      else                                                 wait_cnt <= '0;

      if ((state == WAIT_BND) && (next_state == LOAD_OWN)) begin
        forced   <= !boundary;
        ld_count <= '0;
      end else if (ld_accept && (ld_count != COUNT_MAX)) begin
        ld_count <= ld_count + 1'b1;
      end

      ld_rvalid <= ld_read;
      if (ld_read) ld_rdata <= ram_rdata;
    end
  end

  assign ld_grant  = grant_q;
  assign cpu_hold  = hold_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Directed bench for ram_share_arbiter: a 16x8 RAM model, a per-cycle vector table
// and hand-written sequences for timeout, reset mid-session and simultaneous MAR/grant.
module tb_ram_share_arbiter;

  localparam logic [1:0] S_CPU  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic       clock, reset;
  logic       cpu_mar_in, cpu_ram_in, cpu_ram_out;
  logic [7:0] cpu_bus;
  logic       cpu_step0, cpu_halted, cpu_hold;
  logic [7:0] cpu_rdata;
  logic       ld_req, ld_grant, ld_valid, ld_we;
  logic [3:0] ld_addr;
  logic [7:0] ld_wdata, ld_rdata;
  logic       ld_rvalid;
  logic [4:0] ld_count;
  logic       forced;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       ram_we;
  logic [1:0] state_dbg;

  logic [7:0] mem [16] = '{default: 8'h00};

  int n_vec = 0;
  int n_err = 0;

  ram_share_arbiter #(.ADDR_W(4), .DATA_W(8), .WAIT_MAX(64)) dut (
    .clock(clock), .reset(reset),
    .cpu_mar_in(cpu_mar_in), .cpu_ram_in(cpu_ram_in), .cpu_ram_out(cpu_ram_out),
    .cpu_bus(cpu_bus), .cpu_step0(cpu_step0), .cpu_halted(cpu_halted),
    .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_grant(ld_grant), .ld_valid(ld_valid), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .ld_count(ld_count), .forced(forced),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .state_dbg(state_dbg)
  );

  // Clock / RAM model: synchronous write, asynchronous read.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mi, ri, ro;
    logic [7:0] bus;
    logic       s0, h, rq, v, we;
    logic [3:0] la;
    logic [7:0] lw;
    logic [1:0] st;
    logic       hold, gr;
    logic [3:0] addr;
    logic       ewe, rv;
    logic [7:0] lrd;
    logic [4:0] cnt;
    logic       f;
    logic [7:0] crd;
  } vec_t;

  vec_t rows[$];
  vec_t r;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    cpu_mar_in  = x.mi;  cpu_ram_in = x.ri;  cpu_ram_out = x.ro;  cpu_bus = x.bus;
    cpu_step0   = x.s0;  cpu_halted = x.h;   ld_req = x.rq;       ld_valid = x.v;
    ld_we       = x.we;  ld_addr = x.la;     ld_wdata = x.lw;
  endtask

  task automatic check_row(input int k, input vec_t x);
    chk($sformatf("row%0d state", k),     32'(state_dbg), 32'(x.st));
    chk($sformatf("row%0d cpu_hold", k),  32'(cpu_hold),  32'(x.hold));
    chk($sformatf("row%0d ld_grant", k),  32'(ld_grant),  32'(x.gr));
    chk($sformatf("row%0d ram_addr", k),  32'(ram_addr),  32'(x.addr));
    chk($sformatf("row%0d ram_we", k),    32'(ram_we),    32'(x.ewe));
    chk($sformatf("row%0d ld_rvalid", k), 32'(ld_rvalid), 32'(x.rv));
    chk($sformatf("row%0d ld_rdata", k),  32'(ld_rdata),  32'(x.lrd));
    chk($sformatf("row%0d ld_count", k),  32'(ld_count),  32'(x.cnt));
    chk($sformatf("row%0d forced", k),    32'(forced),    32'(x.f));
    chk($sformatf("row%0d cpu_rdata", k), 32'(cpu_rdata), 32'(x.crd));
  endtask

  initial begin
    int n;
    r = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00,
          S_CPU, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00};
    drive(r);
    reset = 1'b1;
    tick();
    tick();
    chk("reset state",     32'(state_dbg), 32'(S_CPU));
    chk("reset cpu_hold",  32'(cpu_hold),  32'd0);
    chk("reset ld_grant",  32'(ld_grant),  32'd0);
    chk("reset ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("reset ld_count",  32'(ld_count),  32'd0);
    chk("reset forced",    32'(forced),    32'd0);
    chk("reset mar",       32'(ram_addr),  32'd0);
    reset = 1'b0;

    // Fields: mi ri ro bus | s0 h rq v we la lw || st hold gr addr we rv lrd cnt f crd
    // CPU-only access: MAR <- 0x3A, write 0x55, read back.
    rows.push_back('{1'b1,1'b0,1'b0,8'h3A, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'h0,1'b0,1'b0,8'h00,5'd0,1'b0,8'h00});
    rows.push_back('{1'b0,1'b1,1'b0,8'h55, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'hA,1'b1,1'b0,8'h00,5'd0,1'b0,8'h00});
    rows.push_back('{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'hA,1'b0,1'b0,8'h00,5'd0,1'b0,8'h55});
    // Boundary grant: step0 low for 3 cycles of ld_req, CPU keeps access meanwhile.
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'hA,1'b0,1'b0,8'h00,5'd0,1'b0,8'h55});
    rows.push_back('{1'b0,1'b1,1'b0,8'h66, 1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'h00, S_WAIT,1'b0,1'b0,4'hA,1'b1,1'b0,8'h00,5'd0,1'b0,8'h55});
    rows.push_back('{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'h00, S_WAIT,1'b0,1'b0,4'hA,1'b0,1'b0,8'h00,5'd0,1'b0,8'h66});
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,4'h0,8'h00, S_WAIT,1'b0,1'b0,4'hA,1'b0,1'b0,8'h00,5'd0,1'b0,8'h66});
    // Granted: CPU strobes ignored, cpu_rdata held.
    rows.push_back('{1'b1,1'b1,1'b0,8'hEE, 1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'h00, S_LOAD,1'b1,1'b1,4'h0,1'b0,1'b0,8'h00,5'd0,1'b0,8'h66});
    for (int i = 0; i < 16; i++) begin
      r = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b1,4'(i),8'(i*3), S_LOAD,1'b1,1'b1,4'(i),1'b1,1'b0,8'h00,5'(i),1'b0,8'h66};
      rows.push_back(r);
    end
    // Read addr 5 (17th transfer, count saturates), then read addr 10 and drop ld_req.
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,4'h5,8'h00, S_LOAD,1'b1,1'b1,4'h5,1'b0,1'b0,8'h00,5'd16,1'b0,8'h66});
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,4'h5,8'h00, S_LOAD,1'b1,1'b1,4'h5,1'b0,1'b1,8'h0F,5'd16,1'b0,8'h66});
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,4'hA,8'h00, S_LOAD,1'b1,1'b1,4'hA,1'b0,1'b0,8'h0F,5'd16,1'b0,8'h66});
    rows.push_back('{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h3,8'hFF, S_LOAD,1'b1,1'b1,4'h3,1'b0,1'b1,8'h1E,5'd16,1'b0,8'h66});
    rows.push_back('{1'b1,1'b1,1'b0,8'h07, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_REL,1'b0,1'b0,4'hA,1'b0,1'b0,8'h1E,5'd16,1'b0,8'h66});
    // CPU back in control with MAR unchanged.
    rows.push_back('{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'hA,1'b0,1'b0,8'h1E,5'd16,1'b0,8'h1E});
    rows.push_back('{1'b1,1'b0,1'b0,8'h07, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'hA,1'b0,1'b0,8'h1E,5'd16,1'b0,8'h1E});
    rows.push_back('{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00, S_CPU,1'b0,1'b0,4'h7,1'b0,1'b0,8'h1E,5'd16,1'b0,8'h15});

    foreach (rows[k]) begin
      drive(rows[k]);
      #1;
      check_row(k, rows[k]);
      tick();
    end

    // Timeout: no boundary ever, grant after exactly 64 cycles in WAIT_BND.
    r = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00,
          S_CPU, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00};
    drive(r);
    tick();
    n = 0;
    while (state_dbg == S_WAIT && n < 200) begin
      n++;
      tick();
    end
    chk("timeout wait cycles", 32'(n),         32'd64);
    chk("timeout state",       32'(state_dbg), 32'(S_LOAD));
    chk("timeout ld_grant",    32'(ld_grant),  32'd1);
    chk("timeout cpu_hold",    32'(cpu_hold),  32'd1);
    chk("timeout forced",      32'(forced),    32'd1);
    chk("timeout ld_count",    32'(ld_count),  32'd0);

    // Reset in the middle of a loader read.
    ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'h2;
    reset = 1'b1;
    tick();
    reset = 1'b0; ld_valid = 1'b0; ld_req = 1'b0;
    #1;
    chk("midreset state",     32'(state_dbg), 32'(S_CPU));
    chk("midreset cpu_hold",  32'(cpu_hold),  32'd0);
    chk("midreset ld_grant",  32'(ld_grant),  32'd0);
    chk("midreset ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("midreset forced",    32'(forced),    32'd0);
    chk("midreset mar",       32'(ram_addr),  32'd0);
    chk("midreset ld_count",  32'(ld_count),  32'd0);
    chk("midreset ld_rdata",  32'(ld_rdata),  32'd0);

    // Halt-based grant coinciding with a MAR load: MAR takes 0xC, then grant.
    ld_req = 1'b1;
    tick();
    cpu_halted = 1'b1; cpu_mar_in = 1'b1; cpu_bus = 8'h4C;
    tick();
    cpu_halted = 1'b0; cpu_mar_in = 1'b0; cpu_bus = 8'h00;
    #1;
    chk("halt grant state",    32'(state_dbg), 32'(S_LOAD));
    chk("halt grant ld_grant", 32'(ld_grant),  32'd1);
    chk("halt grant forced",   32'(forced),    32'd0);
    ld_req = 1'b0;
    tick();
    chk("halt release state",  32'(state_dbg), 32'(S_REL));
    chk("halt release hold",   32'(cpu_hold),  32'd0);
    tick();
    chk("halt resume state",   32'(state_dbg), 32'(S_CPU));
    chk("halt resume mar",     32'(ram_addr),  32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
